// File: rtl/i2s_audio_source.sv
// I2S master receiver: generates BCLK/LRCLK from CLK and deserialises one 18-bit slot per frame.
// Define I2S_SRC_DECIM_EN to average every 4 captured samples into a single output strobe.
module i2s_audio_source #(
  parameter int DIV_HALF = 24,
  parameter bit CH_RIGHT = 1'b0
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        I2S_BCLK,
  output logic        I2S_LRCLK,
  input  logic        I2S_SD,
  input  logic        RUN,
  output logic [17:0] AUDIO,
  output logic        AUDIORDY,
  output logic        AUDIORUN
);

  localparam int            DW       = $clog2(DIV_HALF);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV_HALF - 1);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          bclk_q, bclk_d;
  logic [5:0]    bit_cnt_q, bit_cnt_d;
  logic          sd_meta_q, sd_sync_q;
  logic [17:0]   shift_q, shift_d;
  logic          run_q, run_d;
  logic          valid_q, valid_d;
  logic [17:0]   audio_q, audio_d;
  logic          rdy_q, rdy_d;

  logic          div_wrap, rise_evt, fall_evt, frame_end;
  logic [4:0]    slot_k;
  logic          capture, strobe_ok;

`ifdef I2S_SRC_DECIM_EN
  logic [19:0]   sum_q, sum_d, sum_next;
  logic [1:0]    phase_q, phase_d;
`endif

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    div_wrap  = (div_cnt_q == DIV_LAST);
    rise_evt  = div_wrap && !bclk_q;
    fall_evt  = div_wrap && bclk_q;
    frame_end = fall_evt && (bit_cnt_q == 6'd63);
    slot_k    = bit_cnt_q[4:0];
    capture   = rise_evt && (slot_k == 5'd18) && (bit_cnt_q[5] == CH_RIGHT);
    strobe_ok = capture && valid_q && run_q;

    div_cnt_d = div_wrap ? '0 : div_cnt_q + DW'(1);
    bclk_d    = div_wrap ? ~bclk_q : bclk_q;
    bit_cnt_d = fall_evt ? bit_cnt_q + 6'd1 : bit_cnt_q;
    run_d     = frame_end ? RUN : run_q;
    valid_d   = frame_end ? 1'b1 : valid_q;

    // Slot bit 0 is the I2S delay bit; bits 1..18 carry MSB..LSB.
    shift_d = shift_q;
    if (rise_evt && (slot_k >= 5'd1) && (slot_k <= 5'd18)) begin
      shift_d = {shift_q[16:0], sd_sync_q};
    end

    audio_d = audio_q;
    rdy_d   = 1'b0;

`ifdef I2S_SRC_DECIM_EN
    sum_next = sum_q + {{2{shift_d[17]}}, shift_d};
    sum_d    = sum_q;
    phase_d  = phase_q;
    if (!run_q) begin
      sum_d   = '0;
      phase_d = '0;
    end else if (strobe_ok) begin
      if (phase_q == 2'd3) begin
        audio_d = sum_next[19:2];
        rdy_d   = 1'b1;
        sum_d   = '0;
        phase_d = '0;
      end else begin
        sum_d   = sum_next;
        phase_d = phase_q + 2'd1;
      end
    end
`else
    if (strobe_ok) begin
      audio_d = shift_d;
      rdy_d   = 1'b1;
    end
`endif
  end

  // NOTE: control state is reset; state updates use non-blocking assignments only.
  always_ff @(posedge CLK) begin
    if (RST) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
      bit_cnt_q <= '0;
      run_q     <= 1'b0;
      valid_q   <= 1'b0;
      audio_q   <= '0;
      rdy_q     <= 1'b0;
`ifdef I2S_SRC_DECIM_EN
      sum_q     <= '0;
      phase_q   <= '0;
`endif
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
      bit_cnt_q <= bit_cnt_d;
      run_q     <= run_d;
      valid_q   <= valid_d;
      audio_q   <= audio_d;
      rdy_q     <= rdy_d;
`ifdef I2S_SRC_DECIM_EN
      sum_q     <= sum_d;
      phase_q   <= phase_d;
`endif
    end
  end

  // NOTE: synchroniser and shift register need no reset; all 18 bits are rewritten before use.
  always_ff @(posedge CLK) begin
    sd_meta_q <= I2S_SD;
    sd_sync_q <= sd_meta_q;
    shift_q   <= shift_d;
  end

  assign I2S_BCLK  = bclk_q;
  assign I2S_LRCLK = bit_cnt_q[5];
  assign AUDIO     = audio_q;
  assign AUDIORDY  = rdy_q;
  assign AUDIORUN  = run_q;

endmodule

// File: doc/i2s_audio_source.md
# i2s_audio_source

I2S master receiver that produces the 18-bit signed audio sample stream (AUDIO / AUDIORDY / AUDIORUN) consumed by the spectrogram display pipeline. It generates BCLK and LRCLK from the 90 MHz system clock and deserialises one channel of a standard I2S frame (two 32-bit slots). It delivers each complete sample as a one-CLK strobe. It sits between the external I2S microphone/ADC pins and the display block's audio ring-buffer writer.

## Interface
- DIV_HALF, 24, CLK cycles per BCLK half-period (≥4); BCLK = 90 MHz / (2·DIV_HALF)
- CH_RIGHT, 0, 0 = capture left slot (LRCLK=0), 1 = capture right slot (LRCLK=1)
- CLK  in  1  system clock, 90 MHz; single clock domain
- RST  in  1  reset, synchronous, active-high
- I2S_BCLK  out  1  bit clock, 50% duty
- I2S_LRCLK  out  1  word select; 0 = left, 1 = right
- I2S_SD  in  1  serial data from codec, asynchronous to CLK
- RUN  in  1  capture enable request
- AUDIO  out  18  signed sample, held between strobes
- AUDIORDY  out  1  one-CLK strobe, AUDIO valid in the same cycle
- AUDIORUN  out  1  capture active, frame-aligned

## Operation
- Divider div_cnt counts 0..DIV_HALF-1. On wrap, BCLK toggles: a rise event when 0→1, a fall event when 1→0.
- bit_cnt (6 bits, 0..63) advances on each fall event and wraps 63→0. A frame boundary is the fall event where bit_cnt wraps.
- LRCLK = bit_cnt[5]; it changes only on fall events.
- SD passes through a 2-FF synchroniser and is sampled on rise events.
- Slot bit index k = bit_cnt[4:0]. k=0 is the I2S one-bit delay slot and is ignored. k=1..18 are the sample MSB..LSB, shifted into an 18-bit register. k=19..31 are ignored.
- Capture completes at the rise event of k=18 in the slot selected by CH_RIGHT.
- run_q is loaded from RUN only at frame boundaries. AUDIORUN = run_q.
- A valid flag clears on reset and sets at the first frame boundary after reset. Captures made before valid is set, or while run_q=0, produce no strobe.
- On a qualifying capture: AUDIO ← shift register, AUDIORDY=1 for exactly one CLK.
- Reset values: I2S_BCLK=0, I2S_LRCLK=0, AUDIO=0, AUDIORDY=0, AUDIORUN=0, div_cnt=0, bit_cnt=0, valid=0.
- RST mid-frame: the partial frame is discarded. No strobe occurs until after the first complete frame following reset.
- RUN falling mid-frame: the current frame's sample is still delivered. AUDIORUN falls at the next boundary.
- RUN rising mid-frame: no effect until the next boundary.

## Timing
- BCLK period: 2·DIV_HALF CLK (48 by default).
- Frame / LRCLK period: 128·DIV_HALF CLK (3072 by default, 29.297 kHz).
- AUDIORDY spacing: exactly one frame, with no jitter.
- Latency: AUDIO and AUDIORDY are registered and asserted 1 CLK after the k=18 rise-event cycle.
- SD is sampled 2 CLK after the pin. This is valid because DIV_HALF ≥ 4 keeps the codec data stable for a half-period.
- AUDIORDY never asserts on two consecutive CLKs.

## Configuration
- I2S_SRC_DECIM_EN defined:
  - Captured samples accumulate into a 20-bit signed sum.
  - Every 4th qualifying capture outputs AUDIO = sum >>> 2 (arithmetic shift) with AUDIORDY, then the sum clears.
  - The phase counter and sum clear on RST and whenever run_q=0.
  - Strobe spacing becomes 4 frames (12288 CLK default, 7.324 kHz).
- I2S_SRC_DECIM_EN undefined: one strobe per frame carrying the raw sample, and no accumulator logic.

## Test plan
- Reset: RST high for 3 CLK → all outputs 0. First BCLK rise comes 24 CLK after RST falls.
- Clocking, default params: BCLK period 48 CLK, LRCLK period 3072 CLK, both at 50% duty. Every LRCLK edge coincides with a BCLK fall.
- Capture: codec model sends left = 18'h20001, right = 18'h1FFFF; CH_RIGHT=0, RUN=1.
  - Expect AUDIO = −131071 with one strobe per frame, starting in frame 2.
  - With CH_RIGHT=1, expect AUDIO = +131071.
- RUN control: deassert RUN at bit_cnt=10 → that frame's strobe still occurs, AUDIORUN falls at the next boundary, and no further strobes occur.
- Reset mid-frame: pulse RST at bit_cnt=12 → no strobe for the partial frame or the following frame, and normal strobes resume after that.
- Decimation, macro defined: left samples 100, 200, 300, −200 → a single strobe with AUDIO = 100, with strobes spaced 12288 CLK.
